// File: rtl/xm23_inst_encoder.sv
// XM23 instruction encoder: packs op index plus operand fields into 16-bit
// instruction words and streams them to consecutive IMEM addresses.
module xm23_inst_encoder #(
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              stop,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        op,
    input  logic [12:0]       off,
    input  logic              rc,
    input  logic              wb,
    input  logic [2:0]        s,
    input  logic [2:0]        d,
    input  logic [7:0]        b,
    input  logic              prpo,
    input  logic              dec,
    input  logic              inc,
    input  logic [4:0]        ccf,
    input  logic [2:0]        pr,
    input  logic [3:0]        sa,
    input  logic [3:0]        cex_c,
    input  logic [2:0]        t,
    input  logic [2:0]        f,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err_illegal,
    output logic [5:0]        err_op
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FULL
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] ptr_q;
    logic              accept;
    logic              legal;
    logic              wr_last;
    logic [15:0]       enc;

    // Group-relative indices; only the low bits matter, so subtract narrow.
    logic [2:0] br_idx;
    logic [3:0] alu_idx;
    logic [2:0] sub_idx;
    logic [1:0] mvl_idx;

    assign in_ready = (state_q == S_RUN) & ~start & ~stop;
    assign accept   = in_valid & in_ready;
    assign legal    = (op < 6'd41);
    assign wr_last  = accept & legal & (ptr_q == LAST);

    assign br_idx  = op[2:0] - 3'd1;
    assign alu_idx = op[3:0] - 4'd9;
    assign sub_idx = op[2:0] - 3'd7;
    assign mvl_idx = op[1:0] - 2'd3;

    always_comb begin
        enc = 16'h0000;
        unique case (1'b1)
            (op == 6'd0):
                enc = {3'b000, off};
            (op >= 6'd1 && op <= 6'd8):
                enc = {3'b001, br_idx, off[9:0]};
            (op >= 6'd9 && op <= 6'd20):
                enc = {4'b0100, alu_idx, rc, wb, s, d};
            (op == 6'd21):
                enc = {8'h4C, 1'b0, wb, s, d};
            (op == 6'd22):
                enc = {8'h4C, 2'b10, s, d};
            (op >= 6'd23 && op <= 6'd25):
                enc = {8'h4D, 1'b0, wb, sub_idx, d};
            (op == 6'd26 || op == 6'd27):
                enc = {8'h4D, 2'b00, sub_idx, d};
            (op == 6'd28):
                enc = {12'h4D8, 1'b0, pr};
            (op == 6'd29):
                enc = {12'h4D9, sa};
            (op == 6'd30):
                enc = {11'b0100_1101_101, ccf};
            (op == 6'd31):
                enc = {11'b0100_1101_110, ccf};
            (op == 6'd32):
                enc = {6'b010100, cex_c, t, f};
            (op == 6'd33):
                enc = {6'b010110, prpo, dec, inc, wb, s, d};
            (op == 6'd34):
                enc = {6'b010111, prpo, dec, inc, wb, s, d};
            (op >= 6'd35 && op <= 6'd38):
                enc = {3'b011, mvl_idx, b, d};
            (op == 6'd39):
                enc = {2'b10, off[6:0], wb, s, d};
            (op == 6'd40):
                enc = {2'b11, off[6:0], wb, s, d};
            default:
                enc = 16'h0000;
        endcase
    end

    always_comb begin
        state_d = state_q;
        if (start)
            state_d = S_RUN;
        else if (stop)
            state_d = S_IDLE;
        else if (state_q == S_RUN && wr_last)
            state_d = S_FULL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= 16'h0000;
            count       <= '0;
            full        <= 1'b0;
            err_illegal <= 1'b0;
            err_op      <= 6'd0;
        end else begin
            mem_we <= 1'b0;
            if (start) begin
                ptr_q       <= start_addr;
                count       <= '0;
                full        <= 1'b0;
                err_illegal <= 1'b0;
                err_op      <= 6'd0;
            end else if (accept) begin
                if (legal) begin
                    mem_we    <= 1'b1;
                    mem_addr  <= ptr_q;
                    mem_wdata <= enc;
                    ptr_q     <= ptr_q + ADDR_W'(1);
                    count     <= count + (ADDR_W + 1)'(1);
                    if (ptr_q == LAST)
                        full <= 1'b1;
                end else begin
                    // Keep the first offender for the loader's diagnostics.
                    err_illegal <= 1'b1;
                    if (!err_illegal)
                        err_op <= op;
                end
            end
        end
    end

endmodule

// File: tb/tb_xm23_inst_encoder.sv
// Self-checking bench for xm23_inst_encoder: directed scenarios plus a
// randomized stream checked against an arithmetic encoding model.
module tb_xm23_inst_encoder;

    localparam int ADDR_W = 15;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic              stop;
    logic              in_valid;
    logic              in_ready;
    logic [5:0]        op;
    logic [12:0]       off;
    logic              rc;
    logic              wb;
    logic [2:0]        s;
    logic [2:0]        d;
    logic [7:0]        b;
    logic              prpo;
    logic              dec;
    logic              inc;
    logic [4:0]        ccf;
    logic [2:0]        pr;
    logic [3:0]        sa;
    logic [3:0]        cex_c;
    logic [2:0]        t;
    logic [2:0]        f;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              err_illegal;
    logic [5:0]        err_op;

    int n_tests;
    int n_fail;

    xm23_inst_encoder #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .stop(stop), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .off(off), .rc(rc), .wb(wb), .s(s), .d(d), .b(b), .prpo(prpo),
        .dec(dec), .inc(inc), .ccf(ccf), .pr(pr), .sa(sa), .cex_c(cex_c),
        .t(t), .f(f), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .count(count), .full(full),
        .err_illegal(err_illegal), .err_op(err_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Encoding straight from the instruction-format table, as sums of fields.
    function automatic logic [15:0] ref_enc(input int o);
        int e;
        int rg;
        rg = int'(wb) * 64 + int'(s) * 8 + int'(d);
        e = 0;
        if (o == 0)
            e = int'(off);
        else if (o <= 8)
            e = 'h2000 + (o - 1) * 1024 + int'(off) % 1024;
        else if (o <= 20)
            e = 'h4000 + (o - 9) * 256 + int'(rc) * 128 + rg;
        else if (o == 21)
            e = 'h4C00 + rg;
        else if (o == 22)
            e = 'h4C80 + int'(s) * 8 + int'(d);
        else if (o <= 25)
            e = 'h4D00 + int'(wb) * 64 + (o - 23) * 8 + int'(d);
        else if (o <= 27)
            e = 'h4D00 + (o - 23) * 8 + int'(d);
        else if (o == 28)
            e = 'h4D80 + int'(pr);
        else if (o == 29)
            e = 'h4D90 + int'(sa);
        else if (o == 30)
            e = 'h4DA0 + int'(ccf);
        else if (o == 31)
            e = 'h4DC0 + int'(ccf);
        else if (o == 32)
            e = 'h5000 + int'(cex_c) * 64 + int'(t) * 8 + int'(f);
        else if (o <= 34)
            e = (o == 33 ? 'h5800 : 'h5C00) + int'(prpo) * 512
                + int'(dec) * 256 + int'(inc) * 128 + rg;
        else if (o <= 38)
            e = 'h6000 + (o - 35) * 2048 + int'(b) * 8 + int'(d);
        else if (o <= 40)
            e = (o == 39 ? 'h8000 : 'hC000) + (int'(off) % 128) * 128 + rg;
        return e[15:0];
    endfunction

    task automatic rand_fields();
        off   = 13'($urandom);
        rc    = 1'($urandom);
        wb    = 1'($urandom);
        s     = 3'($urandom);
        d     = 3'($urandom);
        b     = 8'($urandom);
        prpo  = 1'($urandom);
        dec   = 1'($urandom);
        inc   = 1'($urandom);
        ccf   = 5'($urandom);
        pr    = 3'($urandom);
        sa    = 4'($urandom);
        cex_c = 4'($urandom);
        t     = 3'($urandom);
        f     = 3'($urandom);
    endtask

    task automatic clear_fields();
        {off, rc, wb, s, d, b, prpo, dec, inc} = '0;
        {ccf, pr, sa, cex_c, t, f} = '0;
    endtask

    task automatic start_run(input logic [ADDR_W-1:0] a);
        @(negedge clk);
        in_valid   = 1'b0;
        start_addr = a;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present one op for a cycle; returns 1 ns after the sampling edge.
    task automatic put(input logic v, input int o);
        @(negedge clk);
        in_valid = v;
        op       = 6'(o);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        n_tests++;
        if ({in_ready, mem_we, full, err_illegal} !== 4'b0 ||
            mem_addr !== '0 || mem_wdata !== 16'h0 ||
            count !== '0 || err_op !== 6'd0) begin
            n_fail++;
            $display("FAIL reset: rdy=%b we=%b full=%b err=%b addr=%h wd=%h cnt=%0d eop=%0d, all zero required",
                     in_ready, mem_we, full, err_illegal, mem_addr,
                     mem_wdata, count, err_op);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ready: got %b need 0", in_ready);
        end
    endtask

    task automatic test_add();
        start_run(15'h0100);
        clear_fields();
        s = 3'd1;
        d = 3'd2;
        put(1'b1, 9);
        n_tests++;
        if (mem_we !== 1'b1 || mem_addr !== 15'h0100 || mem_wdata !== 16'h400A) begin
            n_fail++;
            $display("FAIL add: we=%b addr=%h wd=%h need 1 0100 400a",
                     mem_we, mem_addr, mem_wdata);
        end
        put(1'b0, 0);
        n_tests++;
        if (mem_we !== 1'b0 || count !== 16'd1) begin
            n_fail++;
            $display("FAIL add_after: we=%b cnt=%0d need 0 1", mem_we, count);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_w [3];
        int          ops [3];
        exp_w = '{16'h67FB, 16'h3FFF, 16'h4D95};
        ops   = '{35, 8, 29};
        start_run(15'h0100);
        clear_fields();
        for (int i = 0; i < 3; i++) begin
            b   = 8'hFF;
            d   = 3'd3;
            off = 13'h03FF;
            sa  = 4'd5;
            if (i == 1) d = 3'd0;
            put(1'b1, ops[i]);
            n_tests++;
            if (mem_we !== 1'b1 || mem_addr !== 15'(32'h100 + i) ||
                mem_wdata !== exp_w[i]) begin
                n_fail++;
                $display("FAIL b2b[%0d]: we=%b addr=%h wd=%h need 1 %h %h",
                         i, mem_we, mem_addr, mem_wdata, 32'h100 + i, exp_w[i]);
            end
        end
        put(1'b0, 0);
        n_tests++;
        if (mem_we !== 1'b0 || count !== 16'd3) begin
            n_fail++;
            $display("FAIL b2b_count: we=%b cnt=%0d need 0 3", mem_we, count);
        end
    endtask

    task automatic test_illegal();
        start_run(15'h0200);
        clear_fields();
        s = 3'd1;
        d = 3'd2;
        put(1'b1, 9);
        put(1'b1, 41);
        n_tests++;
        if (mem_we !== 1'b0 || err_illegal !== 1'b1 || err_op !== 6'd41) begin
            n_fail++;
            $display("FAIL illegal: we=%b err=%b eop=%0d need 0 1 41",
                     mem_we, err_illegal, err_op);
        end
        put(1'b1, 50);
        n_tests++;
        if (err_op !== 6'd41 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_sticky: eop=%0d we=%b need 41 0", err_op, mem_we);
        end
        put(1'b1, 21);
        n_tests++;
        if (mem_we !== 1'b1 || mem_addr !== 15'h0201 || mem_wdata !== 16'h4C0A) begin
            n_fail++;
            $display("FAIL illegal_next: we=%b addr=%h wd=%h need 1 0201 4c0a",
                     mem_we, mem_addr, mem_wdata);
        end
        put(1'b0, 0);
        n_tests++;
        if (count !== 16'd2) begin
            n_fail++;
            $display("FAIL illegal_count: got %0d need 2", count);
        end
    endtask

    task automatic test_full();
        start_run(15'h7FFE);
        clear_fields();
        put(1'b1, 9);
        n_tests++;
        if (mem_we !== 1'b1 || mem_addr !== 15'h7FFE || full !== 1'b0) begin
            n_fail++;
            $display("FAIL full_w0: we=%b addr=%h full=%b need 1 7ffe 0",
                     mem_we, mem_addr, full);
        end
        put(1'b1, 9);
        n_tests++;
        if (mem_we !== 1'b1 || mem_addr !== 15'h7FFF || full !== 1'b1 ||
            in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_w1: we=%b addr=%h full=%b rdy=%b need 1 7fff 1 0",
                     mem_we, mem_addr, full, in_ready);
        end
        put(1'b1, 9);
        n_tests++;
        if (mem_we !== 1'b0 || count !== 16'd2 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_hold: we=%b cnt=%0d rdy=%b need 0 2 0",
                     mem_we, count, in_ready);
        end
        in_valid = 1'b0;
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stop: rdy=%b need 0", in_ready);
        end
        @(negedge clk);
        start_addr = 15'h0040;
        start      = 1'b1;
        stop       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 1'b1 || full !== 1'b0 || count !== '0) begin
            n_fail++;
            $display("FAIL start_stop: rdy=%b full=%b cnt=%0d need 1 0 0",
                     in_ready, full, count);
        end
    endtask

    task automatic test_async_reset();
        start_run(15'h0010);
        clear_fields();
        put(1'b1, 9);
        n_tests++;
        if (mem_we !== 1'b1 || mem_addr !== 15'h0010) begin
            n_fail++;
            $display("FAIL arst_pre: we=%b addr=%h need 1 0010", mem_we, mem_addr);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== 16'h0 ||
            count !== '0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL arst: we=%b addr=%h wd=%h cnt=%0d rdy=%b need all 0",
                     mem_we, mem_addr, mem_wdata, count, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        put(1'b1, 9);
        n_tests++;
        if (mem_we !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_idle: we=%b rdy=%b need 0 0", mem_we, in_ready);
        end
        put(1'b0, 0);
    endtask

    task automatic test_random();
        int          m_ptr;
        int          m_cnt;
        logic        m_err;
        int          m_eop;
        logic        v;
        int          o;
        logic [15:0] exp;
        logic        exp_we;
        m_ptr = int'($urandom_range(0, 'h1000));
        m_cnt = 0;
        m_err = 1'b0;
        m_eop = 0;
        start_run(15'(m_ptr));
        for (int i = 0; i < 300; i++) begin
            v = ($urandom % 4) != 0;
            if ($urandom % 10 == 0)
                o = 41 + int'($urandom % 23);
            else
                o = int'($urandom % 41);
            rand_fields();
            exp    = ref_enc(o);
            exp_we = v && o <= 40;
            put(v, o);
            n_tests++;
            if (mem_we !== exp_we ||
                (exp_we && (mem_addr !== 15'(m_ptr) || mem_wdata !== exp))) begin
                n_fail++;
                $display("FAIL rand_wr[%0d] op=%0d: we=%b addr=%h wd=%h need %b %h %h",
                         i, o, mem_we, mem_addr, mem_wdata, exp_we, m_ptr, exp);
            end
            if (exp_we) begin
                m_ptr++;
                m_cnt++;
            end else if (v) begin
                if (!m_err) m_eop = o;
                m_err = 1'b1;
            end
            n_tests++;
            if (count !== 16'(m_cnt) || err_illegal !== m_err ||
                err_op !== 6'(m_eop) || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL rand_st[%0d]: cnt=%0d err=%b eop=%0d rdy=%b need %0d %b %0d 1",
                         i, count, err_illegal, err_op, in_ready, m_cnt, m_err, m_eop);
            end
        end
        put(1'b0, 0);
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        start_addr = '0;
        in_valid   = 1'b0;
        op         = 6'd0;
        clear_fields();
        test_reset();
        test_add();
        test_back_to_back();
        test_illegal();
        test_full();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
